// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM states
// and small op-classification helpers.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  function automatic logic op_a_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op inside {OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on magnitudes: shift-add multiply or restoring divide.
// {hi,lo} is the product register (multiply) or {remainder, dividend/quotient} (divide).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] sub;
  logic            ge;

  always_comb begin
    sum   = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    trial = {hi_i, lo_i[XLEN-1]};
    ge    = trial >= {1'b0, b_i};
    // remainder stays below the divisor, so the difference always fits XLEN bits
    sub   = trial[XLEN-1:0] - b_i;
    if (div_i) begin
      hi_o = ge ? sub : trial[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = sum[XLEN:1];
      lo_o = {sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV-style multiply/divide unit: one bit per cycle, valid/ready on both
// sides, sign handling and divide special cases resolved around the step datapath.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned    CNT_W   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e             state_q;
  op_e                op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [XLEN-1:0]    hi_q, lo_q, b_q, result_q;
  logic [TAG_W-1:0]   tag_q;
  logic               neg_q, negr_q;

  op_e                op_in;
  logic               a_neg, b_neg, in_div, in_rem, div_zero, div_ovf;
  logic [XLEN-1:0]    a_mag, b_mag, special_res;

  always_comb begin
    op_in       = op_e'(in_op);
    a_neg       = op_a_signed(op_in) & in_a[XLEN-1];
    b_neg       = op_b_signed(op_in) & in_b[XLEN-1];
    a_mag       = a_neg ? -in_a : in_a;
    b_mag       = b_neg ? -in_b : in_b;
    in_div      = op_is_div(op_in);
    in_rem      = op_is_rem(op_in);
    div_zero    = in_div && (in_b == '0);
    div_ovf     = (op_in == OP_DIV || op_in == OP_REM) && (in_a == MIN_NEG) && (in_b == '1);
    special_res = div_zero ? (in_rem ? in_a : '1) : (in_rem ? '0 : in_a);
  end

  logic [XLEN-1:0]   hi_n, lo_n, fin_res;
  logic [2*XLEN-1:0] prod;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .div_i (op_is_div(op_q)),
    .hi_i  (hi_q),
    .lo_i  (lo_q),
    .b_i   (b_q),
    .hi_o  (hi_n),
    .lo_o  (lo_n)
  );

  // Sign correction applied to the step output on the final BUSY cycle.
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    case (op_q)
      OP_MUL:                       fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = neg_q ? -lo_n : lo_n;
      default:                      fin_res = negr_q ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      tag_q    <= '0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q   <= op_in;
            tag_q  <= in_tag;
            neg_q  <= a_neg ^ b_neg;
            negr_q <= a_neg;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              state_q  <= S_DONE;
            end else begin
              // multiply keeps the multiplier in lo and the multiplicand in b
              hi_q    <= '0;
              lo_q    <= in_div ? a_mag : b_mag;
              b_q     <= in_div ? b_mag : a_mag;
              cnt_q   <= CNT_W'(XLEN);
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          hi_q  <= hi_n;
          lo_q  <= lo_n;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            result_q <= fin_res;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule
